// File: rtl/hex_counter_display.sv
// BCD up/down counter with a free-running prescaler driving registered
// active-low 7-segment outputs with leading-zero blanking and blink.
//
// Ports:
//   CLOCK_50  sole clock
//   RST_N     asynchronous active-low reset
//   en        count enable
//   up        direction (1 = increment)
//   load      synchronous load strobe
//   load_val  BCD load value, digit 0 in [3:0]
//   blink     display blink enable
//   count     current BCD count
//   carry     one-cycle wrap pulse
//   HEX       active-low segments, digit k in [7k+6:7k], a at 7k+6
module hex_counter_display #(
  parameter int N_DIGITS = 4,
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  CLOCK_50,
  input  logic                  RST_N,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  input  logic                  blink,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  carry,
  output logic [7*N_DIGITS-1:0] HEX
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Display of a zero count: "0" in digit 0, higher
  // digits blank or "0" depending on blanking.
  function automatic logic [7*N_DIGITS-1:0] hex_rst();
    logic [7*N_DIGITS-1:0] v;
    v = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (k == 0 || !BLANK_LZ)
        v[7*k +: 7] = 7'b0000001;
    end
    return v;
  endfunction

  localparam logic [7*N_DIGITS-1:0] HEX_RST = hex_rst();

  logic [PW-1:0]         presc;
  logic                  phase;
  logic                  wrap;
  logic [4*N_DIGITS-1:0] ld_bcd;
  logic [4*N_DIGITS-1:0] nxt;
  logic                  ripple;
  logic [3:0]            d;
  logic [7*N_DIGITS-1:0] hex_d;
  logic                  seen;

  assign wrap = (presc == PMAX);

  // Out-of-range nibbles load as zero.
  always_comb begin
    ld_bcd = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (load_val[4*k +: 4] <= 4'd9)
        ld_bcd[4*k +: 4] = load_val[4*k +: 4];
    end
  end

  // BCD ripple step; ripple survives only if
  // every digit wrapped (all-9s up, all-0s down).
  always_comb begin
    nxt    = count;
    ripple = 1'b1;
    d      = 4'd0;
    for (int k = 0; k < N_DIGITS; k++) begin
      d = count[4*k +: 4];
      if (ripple) begin
        if (up) begin
          if (d == 4'd9) begin
            nxt[4*k +: 4] = 4'd0;
          end else begin
            nxt[4*k +: 4] = d + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            nxt[4*k +: 4] = 4'd9;
          end else begin
            nxt[4*k +: 4] = d - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
  end

  // Scan from the top: a digit is blank until
  // the first nonzero digit is seen. Digit 0
  // is always shown.
  always_comb begin
    hex_d = '1;
    seen  = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      if (count[4*k +: 4] != 4'd0)
        seen = 1'b1;
      if (!(BLANK_LZ && k != 0 && !seen))
        hex_d[7*k +: 7] = seg7(count[4*k +: 4]);
    end
    if (blink && phase)
      hex_d = '1;
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      presc <= '0;
      count <= '0;
      carry <= 1'b0;
      phase <= 1'b0;
      HEX   <= HEX_RST;
    end else begin
      HEX   <= hex_d;
      carry <= 1'b0;
      if (load) begin
        count <= ld_bcd;
        presc <= '0;
        phase <= 1'b0;
      end else begin
        if (wrap) begin
          presc <= '0;
          phase <= ~phase;
        end else begin
          presc <= presc + PW'(1);
        end
        if (wrap && en) begin
          count <= nxt;
          carry <= ripple;
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_counter_display.sv
// Bench for hex_counter_display: integer-valued reference
// model checked every cycle plus directed literal checks.
module tb_hex_counter_display;

  localparam int N   = 4;
  localparam int DIV = 8;

  localparam logic [6:0] SEG [10] = '{
    7'h01, 7'h4f, 7'h12, 7'h06, 7'h4c,
    7'h24, 7'h20, 7'h0f, 7'h00, 7'h04
  };
  localparam logic [6:0] BL = 7'h7f;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic        blink;
  logic [15:0] count;
  logic        carry;
  logic [27:0] hex;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk   = 0;

  hex_counter_display #(
    .N_DIGITS(N),
    .CLK_HZ  (8),
    .TICK_HZ (1),
    .BLANK_LZ(1'b1)
  ) dut (
    .CLOCK_50(clk),
    .RST_N   (rst_n),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .blink   (blink),
    .count   (count),
    .carry   (carry),
    .HEX     (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] hex_of(
    input int v, input bit ph, input bit bl
  );
    logic [27:0] h;
    int p;
    h = '1;
    if (bl && ph) return h;
    p = 1;
    for (int k = 0; k < N; k++) begin
      if (k > 0 && v < p) h[7*k +: 7] = BL;
      else h[7*k +: 7] = SEG[(v / p) % 10];
      p = p * 10;
    end
    return h;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] b;
    int p;
    p = 1;
    for (int k = 0; k < N; k++) begin
      b[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return b;
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    int v;
    int p;
    v = 0;
    p = 1;
    for (int k = 0; k < N; k++) begin
      if (b[4*k +: 4] <= 4'd9)
        v = v + p * int'(b[4*k +: 4]);
      p = p * 10;
    end
    return v;
  endfunction

  int          m_cnt;
  int          m_pre;
  bit          m_ph;
  bit          m_carry;
  logic [27:0] m_hex;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      m_pre   <= 0;
      m_ph    <= 1'b0;
      m_carry <= 1'b0;
      m_hex   <= hex_of(0, 1'b0, 1'b0);
    end else begin
      m_hex   <= hex_of(m_cnt, m_ph, blink);
      m_carry <= 1'b0;
      if (load) begin
        m_cnt <= bcd2int(load_val);
        m_pre <= 0;
        m_ph  <= 1'b0;
      end else begin
        m_pre <= (m_pre == DIV - 1) ? 0 : m_pre + 1;
        if (m_pre == DIV - 1) m_ph <= ~m_ph;
        if (m_pre == DIV - 1 && en) begin
          if (up) begin
            m_cnt   <= (m_cnt + 1) % 10000;
            m_carry <= (m_cnt == 9999);
          end else begin
            m_cnt   <= (m_cnt + 9999) % 10000;
            m_carry <= (m_cnt == 0);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      n_cmp++;
      if (count !== int2bcd(m_cnt) || carry !== m_carry ||
          hex !== m_hex) begin
        n_bad++;
        $display("FAIL model t=%0t count=%h/%h carry=%b/%b hex=%h/%h",
                 $time, count, int2bcd(m_cnt), carry, m_carry,
                 hex, m_hex);
      end
    end
  end

  task automatic expect_v(
    input string nm, input logic [27:0] act, input logic [27:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    up       = 1'b1;
    load     = 1'b0;
    load_val = 16'h0;
    blink    = 1'b0;
    cyc(2);
    chk = 1;
    expect_v("rst_count", 28'(count), 28'h0);
    expect_v("rst_hex", hex, {BL, BL, BL, 7'h01});
    rst_n = 1'b1;

    cyc(8);
    expect_v("up_cnt1", 28'(count), 28'h0001);
    cyc(1);
    expect_v("up_hex1", hex, {BL, BL, BL, 7'h4f});
    cyc(7);
    expect_v("up_cnt2", 28'(count), 28'h0002);

    load_val = 16'h9999;
    load     = 1'b1;
    cyc(1);
    load = 1'b0;
    expect_v("ld9999", 28'(count), 28'h9999);
    cyc(8);
    expect_v("ovf_cnt", 28'(count), 28'h0000);
    expect_v("ovf_carry", 28'(carry), 28'h1);
    cyc(1);
    expect_v("ovf_carry_lo", 28'(carry), 28'h0);
    expect_v("ovf_hex", hex, {BL, BL, BL, 7'h01});

    load_val = 16'h0000;
    up       = 1'b0;
    load     = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(8);
    expect_v("unf_cnt", 28'(count), 28'h9999);
    expect_v("unf_carry", 28'(carry), 28'h1);
    cyc(1);
    expect_v("unf_hex", hex, {4{7'h04}});

    load_val = 16'h12A5;
    up       = 1'b1;
    load     = 1'b1;
    cyc(1);
    load = 1'b0;
    expect_v("ld_bad_nib", 28'(count), 28'h1205);
    cyc(7);
    load_val = 16'h0042;
    load     = 1'b1;
    cyc(1);
    load = 1'b0;
    expect_v("ld_on_wrap", 28'(count), 28'h0042);
    expect_v("ld_on_wrap_c", 28'(carry), 28'h0);
    cyc(7);
    expect_v("restart_hold", 28'(count), 28'h0042);
    cyc(1);
    expect_v("restart_step", 28'(count), 28'h0043);

    blink = 1'b1;
    en    = 1'b0;
    cyc(1);
    expect_v("blink_off", hex, 28'hfffffff);
    cyc(8);
    expect_v("blink_on", hex, {BL, BL, 7'h4c, 7'h06});
    expect_v("frozen", 28'(count), 28'h0043);
    cyc(3);

    #2 rst_n = 1'b0;
    #1;
    expect_v("arst_cnt", 28'(count), 28'h0);
    expect_v("arst_hex", hex, {BL, BL, BL, 7'h01});
    expect_v("arst_carry", 28'(carry), 28'h0);
    cyc(2);
    en    = 1'b1;
    blink = 1'b0;
    rst_n = 1'b1;
    cyc(7);
    expect_v("post_rst_hold", 28'(count), 28'h0);
    cyc(1);
    expect_v("post_rst_step", 28'(count), 28'h0001);
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
